vga_rect_fill: RTL and testbench

// Upstream drawing engine for the VGA frame-buffer interface. Accepts rectangle-fill commands
// (two corners + 8-bit grey level) over a valid/ready handshake, normalises and clips them
// to the 320x240 buffer, and emits one pixel write (x, y, colour) per cycle in row-major order.
// Its x_out/y_out/color_out/pix_valid drive the interface's x_in/y_in/r_in and write enable.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_rect_fill_if.sv | 31 +++
 rtl/vga_rect_clip.sv | 28 ++
 rtl/vga_rect_fill.sv | 116 +++++++++++
 tb/tb_vga_rect_fill.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA drawing constants, coordinate/pixel types and the rectangle-fill FSM states.
// Imported by the fill engine, its clip helper and the command/pixel interface.
package vga_pkg;
    localparam int H_RES   = 320;
    localparam int V_RES   = 240;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 8;

    typedef logic [X_W-1:0]     coord_x_t;
    typedef logic [Y_W-1:0]     coord_y_t;
    typedef logic [COLOR_W-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} fill_state_t;

    localparam coord_x_t X_LAST  = coord_x_t'(H_RES - 1);
    localparam coord_y_t Y_LAST  = coord_y_t'(V_RES - 1);
    localparam coord_x_t X_LIMIT = coord_x_t'(H_RES);
    localparam coord_y_t Y_LIMIT = coord_y_t'(V_RES);
endpackage

// File: rtl/vga_rect_fill_if.sv
// Command (valid/ready) and pixel-write (valid/ready) bundle of the rectangle-fill engine.
// Both channels: a transfer happens on a clock edge where valid && ready; valid holds its payload until then.
interface vga_rect_fill_if;
    import vga_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    coord_x_t    cmd_x0;
    coord_y_t    cmd_y0;
    coord_x_t    cmd_x1;
    coord_y_t    cmd_y1;
    pixel_t      cmd_color;
    logic        pix_valid;
    logic        pix_ready;
    coord_x_t    x_out;
    coord_y_t    y_out;
    pixel_t      color_out;
    logic        busy;
    logic        done;
    fill_state_t state;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
        input  cmd_ready, pix_valid, x_out, y_out, color_out, busy, done, state
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, pix_ready,
        output cmd_ready, pix_valid, x_out, y_out, color_out, busy, done, state
    );
endinterface

// File: rtl/vga_rect_clip.sv
// Combinational corner normalisation and clipping of a rectangle to the visible buffer.
// empty flags a rectangle lying wholly right of or below the buffer.
module vga_rect_clip
    import vga_pkg::*;
(
    input  coord_x_t x0,
    input  coord_y_t y0,
    input  coord_x_t x1,
    input  coord_y_t y1,
    output coord_x_t xlo,
    output coord_x_t xhi,
    output coord_y_t ylo,
    output coord_y_t yhi,
    output logic     empty
);
    coord_x_t xmax;
    coord_y_t ymax;

    always_comb begin
        xlo   = (x0 < x1) ? x0 : x1;
        xmax  = (x0 < x1) ? x1 : x0;
        ylo   = (y0 < y1) ? y0 : y1;
        ymax  = (y0 < y1) ? y1 : y0;
        xhi   = (xmax > X_LAST) ? X_LAST : xmax;
        yhi   = (ymax > Y_LAST) ? Y_LAST : ymax;
        empty = (xlo >= X_LIMIT) || (ylo >= Y_LIMIT);
    end
endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill drawing engine: latches a command, clips it in SETUP, then scans
// the rectangle row-major emitting one pixel write per accepted pixel handshake.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    vga_rect_fill_if.slave bus
);
    fill_state_t state_q, state_d;
    coord_x_t    x0_q, x1_q, xlo_q, xhi_q, x_q, x_d;
    coord_y_t    y0_q, y1_q, ylo_q, yhi_q, y_q, y_d;
    pixel_t      color_q, col_q, col_d;
    logic        pv_q, ready_q, busy_q, done_q;
    coord_x_t    clip_xlo, clip_xhi;
    coord_y_t    clip_ylo, clip_yhi;
    logic        clip_empty;
    logic        accept;

    vga_rect_clip u_clip (
        .x0    (x0_q),
        .y0    (y0_q),
        .x1    (x1_q),
        .y1    (y1_q),
        .xlo   (clip_xlo),
        .xhi   (clip_xhi),
        .ylo   (clip_ylo),
        .yhi   (clip_yhi),
        .empty (clip_empty)
    );

    assign accept = bus.cmd_valid && ready_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        case (state_q)
            IDLE:  if (accept) state_d = SETUP;
            SETUP: begin
                if (clip_empty) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAW;
                    x_d     = clip_xlo;
                    y_d     = clip_ylo;
                    col_d   = color_q;
                end
            end
            DRAW: begin
                // The final pixel leaves x/y untouched so the outputs keep its coordinates.
                if (bus.pix_ready) begin
                    if (x_q == xhi_q && y_q == yhi_q) begin
                        state_d = DONE;
                    end else if (x_q == xhi_q) begin
                        x_d = xlo_q;
                        y_d = y_q + coord_y_t'(1);
                    end else begin
                        x_d = x_q + coord_x_t'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            pv_q    <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            pv_q    <= (state_d == DRAW);
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    // Command and clipped bounds are pure data; the FSM decides when they matter.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && accept) begin
            x0_q    <= bus.cmd_x0;
            y0_q    <= bus.cmd_y0;
            x1_q    <= bus.cmd_x1;
            y1_q    <= bus.cmd_y1;
            color_q <= bus.cmd_color;
        end
        if (state_q == SETUP) begin
            xlo_q <= clip_xlo;
            xhi_q <= clip_xhi;
            ylo_q <= clip_ylo;
            yhi_q <= clip_yhi;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.pix_valid = pv_q;
    assign bus.x_out     = x_q;
    assign bus.y_out     = y_q;
    assign bus.color_out = col_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_vga_rect_fill.sv
// Self-checking bench for vga_rect_fill: a rectangle model fills an expected-pixel queue,
// a negedge monitor pops and compares every handshaken pixel, and timing/control are checked inline.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_rect_fill_if bus ();

    vga_rect_fill dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [26:0] exp_q[$];
    bit          sb_en = 1'b1;
    int          pix_cnt = 0;
    int          done_cnt = 0;
    int          first_pix_cyc = -1;
    logic [26:0] last_pix = '0;
    logic [26:0] pix_w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every handshaken pixel is checked against the head of the queue.
    always @(negedge clk) begin
        if (bus.pix_valid && bus.pix_ready) begin
            pix_w = {bus.x_out, bus.y_out, bus.color_out};
            pix_cnt++;
            if (first_pix_cyc < 0) first_pix_cyc = cyc;
            last_pix = pix_w;
            if (sb_en) begin
                if (exp_q.size() == 0) check("sb_extra_pixel", 32'(pix_w), 32'hFFFF_FFFF);
                else                   check("sb_pixel", 32'(pix_w), 32'(exp_q.pop_front()));
            end
        end
        if (bus.done) done_cnt++;
    end

    task automatic push_rect(input int x0, input int y0, input int x1, input int y1,
                             input int c, output int n);
        int xlo, xhi, ylo, yhi;
        xlo = (x0 < x1) ? x0 : x1;
        xhi = (x0 < x1) ? x1 : x0;
        ylo = (y0 < y1) ? y0 : y1;
        yhi = (y0 < y1) ? y1 : y0;
        if (xhi > H_RES - 1) xhi = H_RES - 1;
        if (yhi > V_RES - 1) yhi = V_RES - 1;
        n = 0;
        if (xlo >= H_RES || ylo >= V_RES) return;
        for (int y = ylo; y <= yhi; y++)
            for (int x = xlo; x <= xhi; x++) begin
                exp_q.push_back({10'(x), 9'(y), 8'(c)});
                n++;
            end
    endtask

    task automatic wait_ready();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.cmd_ready) got = 1'b1;
            else @(negedge clk);
        end
        check("wait_cmd_ready", 32'(got), 32'd1);
    endtask

    // Drives one command at a negedge; afterwards keeps cmd_valid high with junk
    // until done so that any illegal second accept shows up as extra pixels.
    task automatic run_cmd(input int x0, input int y0, input int x1, input int y1,
                           input int c, input bit timing);
        int n, acc, done_at, dc0;
        bit got;
        pix_cnt       = 0;
        first_pix_cyc = -1;
        dc0           = done_cnt;
        done_at       = 0;
        push_rect(x0, y0, x1, y1, c, n);
        wait_ready();
        bus.cmd_x0    = 10'(x0);
        bus.cmd_y0    = 9'(y0);
        bus.cmd_x1    = 10'(x1);
        bus.cmd_y1    = 9'(y1);
        bus.cmd_color = 8'(c);
        bus.cmd_valid = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1;
        bus.cmd_x0    = 10'd5;
        bus.cmd_y0    = 9'd5;
        bus.cmd_x1    = 10'd6;
        bus.cmd_y1    = 9'd6;
        bus.cmd_color = 8'hEE;
        @(negedge clk);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        check("ready_low_setup", 32'(bus.cmd_ready), 32'd0);
        check("state_setup", 32'(bus.state), 32'(SETUP));
        got = 1'b0;
        for (int i = 0; i < 80000 && !got; i++) begin
            if (bus.done) begin
                got     = 1'b1;
                done_at = cyc;
            end else begin
                @(negedge clk);
            end
        end
        bus.cmd_valid = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        if (timing) begin
            check("done_cycle", 32'(done_at), 32'(acc + 2 + n));
            if (n > 0) check("first_pix_cycle", 32'(first_pix_cyc), 32'(acc + 2));
        end
        @(negedge clk);
        check("ready_after_done", 32'(bus.cmd_ready), 32'd1);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
        check("pix_count", 32'(pix_cnt), 32'(n));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_pulses", 32'(done_cnt - dc0), 32'd1);
    endtask

    task automatic backpressure_hold();
        bit got = 1'b0;
        logic [26:0] held;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.pix_valid) got = 1'b1;
        end
        check("bp_first_valid", 32'(got), 32'd1);
        held = {bus.x_out, bus.y_out, bus.color_out};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_pixel", 32'({bus.x_out, bus.y_out, bus.color_out}), 32'(held));
            check("bp_hold_valid", 32'(bus.pix_valid), 32'd1);
        end
        @(posedge clk);
        #1 bus.pix_ready = 1'b1;
    endtask

    task automatic reset_mid_draw();
        bit got = 1'b0;
        int dc0;
        bit seen;
        sb_en   = 1'b0;
        pix_cnt = 0;
        dc0     = done_cnt;
        wait_ready();
        bus.cmd_x0    = 10'd100;
        bus.cmd_y0    = 9'd100;
        bus.cmd_x1    = 10'd103;
        bus.cmd_y1    = 9'd103;
        bus.cmd_color = 8'h77;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.pix_valid) got = 1'b1;
        end
        check("rst_draw_started", 32'(got), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_state_idle", 32'(bus.state), 32'(IDLE));
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pix_valid || bus.done) seen = 1'b1;
        end
        check("rst_quiet_after", 32'(seen), 32'd0);
        check("rst_pix_count", 32'(pix_cnt), 32'd3);
        check("rst_no_done", 32'(done_cnt - dc0), 32'd0);
        sb_en = 1'b1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_x1    = '0;
        bus.cmd_y1    = '0;
        bus.cmd_color = '0;
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("reset_outputs", 32'({bus.x_out, bus.y_out, bus.color_out}), 32'd0);
        check("reset_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        check("reset_state", 32'(bus.state), 32'(IDLE));

        run_cmd(2, 1, 4, 2, 8'h80, 1'b1);
        check("hold_after_draw", 32'({bus.x_out, bus.y_out, bus.color_out}),
              32'({10'd4, 9'd2, 8'h80}));
        check("idle_pix_valid", 32'(bus.pix_valid), 32'd0);
        run_cmd(10, 5, 8, 4, 8'h41, 1'b1);
        run_cmd(318, 238, 400, 300, 8'hC5, 1'b1);
        run_cmd(320, 0, 330, 5, 8'h11, 1'b1);
        check("empty_keeps_outputs", 32'({bus.x_out, bus.y_out, bus.color_out}),
              32'({10'd319, 9'd239, 8'hC5}));
        run_cmd(7, 9, 7, 9, 8'hAA, 1'b1);

        bus.pix_ready = 1'b0;
        fork
            run_cmd(50, 60, 51, 60, 8'h33, 1'b0);
            backpressure_hold();
        join

        reset_mid_draw();
        run_cmd(0, 0, 1, 1, 8'h5A, 1'b1);

        run_cmd(0, 0, H_RES - 1, V_RES - 1, 8'h00, 1'b1);
        check("full_clear_last", 32'(last_pix), 32'({10'd319, 9'd239, 8'h00}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
